reg_scoreboard: RTL and testbench
=================================

// Module: reg_scoreboard
// PURPOSE
//  Parametrised register-file write tracker for the pipelined CPU.
//  - Decodes issue and writeback destination addresses to one-hot.
//  - Keeps a per-register count of in-flight writes.
//  - Outputs busy status for hazard/stall logic and a gated one-hot write enable for the register array.
//  - Supersedes the fixed 5:32 write-enable decoder; adds zero-register masking, multiple outstanding writes and source-busy lookups.
// PARAMETERS
//  ADDR_W    5            register address width
//  NUM_REGS  2**ADDR_W    registers tracked
//  ZERO_REG  31           hard-wired zero register; never busy, never written
//  CNT_W     2            pending-count width; max in-flight writes per reg = 2**CNT_W-1
//  NUM_RD    2            number of source-operand busy lookup ports
// PORTS
//  clk          in   1               clock, rising edge
//  reset        in   1               synchronous, active-low
//  issue_valid  in   1               instruction with destination is issuing
//  issue_rd     in   ADDR_W          destination register of issuing instr
//  issue_ready  out  1               issue accepted this cycle when issue_valid && issue_ready
//  wb_valid     in   1               writeback occurring this cycle
//  wb_rd        in   ADDR_W          writeback destination register
//  we_en        out  NUM_REGS        one-hot register-array write enable
//  rd_addr      in   NUM_RD*ADDR_W   source register addresses, packed
//  rd_busy      out  NUM_RD          source has an outstanding write
//  busy_vec     out  NUM_REGS        per-register busy, count != 0
//  underflow    out  1               sticky: writeback with no pending write
// BEHAVIOUR
//  - Reset (reset==0 at a clk edge):
//    - All counters and underflow clear to 0.
//    - busy_vec, rd_busy are 0 from the next cycle; issue_ready reads 1.
//    - Reset overrides any issue or writeback in the same cycle.
//  - we_en (combinational):
//    - we_en = onehot(wb_rd) when wb_valid, else 0.
//    - Bit ZERO_REG is always 0.
//    - Any address >= NUM_REGS gives all-zero.
//  - Counter update per register r, at the clk edge:
//    - inc = accepted issue to r; dec = wb_valid to r with cnt[r] != 0.
//    - inc&&!dec: +1. dec&&!inc: -1. Both or neither: hold.
//    - Same-reg issue+writeback in one cycle nets zero.
//    - ZERO_REG counter is never modified; stays 0.
//  - issue_ready (combinational):
//    - Reads 0 only when issue_rd != ZERO_REG, cnt[issue_rd] == 2**CNT_W-1, and there is no same-cycle writeback to issue_rd.
//    - Otherwise reads 1. Never saturate or wrap.
//  - Busy latency:
//    - busy_vec and rd_busy reflect registered counters only; there is no same-cycle bypass.
//    - Issue accepted in cycle N gives busy visible in N+1.
//    - Writeback that drops cnt to 0 in cycle N gives not-busy in N+1.
//    - rd_busy[i] = busy_vec[rd_addr[i]]; ZERO_REG always reads 0.
//  - Underflow:
//    - wb_valid to a register other than ZERO_REG with cnt == 0 and no same-cycle issue to it:
//      - Counter holds at 0.
//      - we_en is still driven.
//      - underflow is set and held until reset.
//  - No FSM; state is NUM_REGS counters of CNT_W bits plus the underflow flag.
// STRUCTURE
//  - Shared package cpu_regfile_pkg:
//    - reg_addr_t (logic [ADDR_W-1:0])
//    - ZERO_REG, NUM_REGS constants.
//  - Sub-module onehot_decoder #(IN_W):
//    - Ports: in, enable -> out[2**IN_W].
//    - Instantiated twice: issue path and writeback path.
//  - Per-register counters generated with a for-generate loop.
// TESTING
//  1. Reset mid-run:
//     - Stimulus: cnt[3]=2 and underflow=1, then reset=0 for one edge.
//     - Response: busy_vec=0, underflow=0, issue_ready=1.
//  2. Issue, then writeback:
//     - Stimulus: issue rd=5 in cycle 0; wb rd=5 in cycle 3.
//     - Response: busy_vec[5]=1 in cycles 1-3, 0 in cycle 4; we_en=32'h20 in cycle 3 only; rd_busy follows when rd_addr=5.
//  3. Zero register:
//     - Stimulus: issue rd=31, then wb rd=31.
//     - Response: busy_vec[31] stays 0; we_en=0; underflow stays 0.
//  4. Saturation:
//     - Stimulus: 3 issues to rd=7, then a 4th.
//     - Response: issue_ready=0 on the 4th.
//     - Stimulus: add wb rd=7 in the same cycle.
//     - Response: issue_ready=1; cnt stays 3.
//  5. Simultaneous events:
//     - Stimulus: issue rd=9 and wb rd=9 in the same cycle with cnt[9]=1.
//     - Response: cnt[9] remains 1; busy_vec[9]=1.
//     - Stimulus: issue rd=2 with wb rd=4 in the same cycle.
//     - Response: both counters update independently.
//  6. Underflow:
//     - Stimulus: wb rd=12 with cnt[12]=0.
//     - Response: we_en=32'h1000; underflow=1 next cycle and held; cnt[12]=0.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared register-file constants and types for the CPU register scoreboard.
package cpu_regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int ZERO_REG = 31;
    localparam int CNT_W    = 2;
    localparam int NUM_RD   = 2;

    typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue / writeback / lookup bus between the pipeline and the register scoreboard.
interface reg_scoreboard_if #(
    parameter int ADDR_W   = cpu_regfile_pkg::ADDR_W,
    parameter int NUM_REGS = cpu_regfile_pkg::NUM_REGS,
    parameter int NUM_RD   = cpu_regfile_pkg::NUM_RD
);

    logic                     issue_valid;
    logic [ADDR_W-1:0]        issue_rd;
    logic                     issue_ready;
    logic                     wb_valid;
    logic [ADDR_W-1:0]        wb_rd;
    logic [NUM_REGS-1:0]      we_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_REGS-1:0]      busy_vec;
    logic                     underflow;

    modport master (
        output issue_valid, issue_rd, wb_valid, wb_rd, rd_addr,
        input  issue_ready, we_en, rd_busy, busy_vec, underflow
    );

    modport slave (
        input  issue_valid, issue_rd, wb_valid, wb_rd, rd_addr,
        output issue_ready, we_en, rd_busy, busy_vec, underflow
    );

endinterface

// File: rtl/reg_scoreboard_dec.sv
// Binary-to-one-hot decoder with enable; all-zero output when disabled.
module onehot_decoder #(
    parameter int IN_W = 5
) (
    input  logic [IN_W-1:0]    in,
    input  logic               enable,
    output logic [2**IN_W-1:0] out
);

    // Set exactly the addressed bit when enabled.
    always_comb begin
        out = '0;
        for (int unsigned i = 0; i < 2 ** IN_W; i++) begin
            if (enable && (in == IN_W'(i))) begin
                out[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register-file write tracker: per-register in-flight write counters, busy
// lookups for hazard logic and gated one-hot write enables.
module reg_scoreboard
    import cpu_regfile_pkg::*;
#(
    parameter int ADDR_W   = cpu_regfile_pkg::ADDR_W,
    parameter int NUM_REGS = cpu_regfile_pkg::NUM_REGS,
    parameter int ZERO_REG = cpu_regfile_pkg::ZERO_REG,
    parameter int CNT_W    = cpu_regfile_pkg::CNT_W,
    parameter int NUM_RD   = cpu_regfile_pkg::NUM_RD
) (
    input  logic           clk,
    input  logic           reset,
    reg_scoreboard_if.slave bus
);

    localparam logic [CNT_W-1:0]    CNT_MAX   = '1;
    localparam logic [NUM_REGS-1:0] ZERO_MASK = NUM_REGS'(1) << ZERO_REG;

    logic [CNT_W-1:0]     cnt [NUM_REGS];
    logic [NUM_REGS-1:0]  busyVec;
    logic [NUM_REGS-1:0]  issueOh;
    logic [NUM_REGS-1:0]  wbOh;
    logic [NUM_REGS-1:0]  incVec;
    logic [NUM_REGS-1:0]  decVec;
    logic [NUM_REGS-1:0]  ufVec;
    logic [2**ADDR_W-1:0] issueDec;
    logic [2**ADDR_W-1:0] wbDec;
    logic                 issueReady;
    logic                 issueAccept;
    logic                 underflowQ;
    logic [ADDR_W-1:0]    rdSel;

    function automatic logic inRange(input logic [ADDR_W-1:0] a);
        return int'(a) < NUM_REGS;
    endfunction

    // Stall only a full counter, unless a same-cycle writeback frees a slot.
    always_comb begin
        issueReady = 1'b1;
        if (inRange(bus.issue_rd) && (int'(bus.issue_rd) != ZERO_REG) &&
            (cnt[bus.issue_rd] == CNT_MAX) &&
            !(bus.wb_valid && (bus.wb_rd == bus.issue_rd))) begin
            issueReady = 1'b0;
        end
    end

    assign issueAccept = bus.issue_valid && issueReady;

    onehot_decoder #(.IN_W(ADDR_W)) issueDecoder (
        .in     (bus.issue_rd),
        .enable (issueAccept),
        .out    (issueDec)
    );

    onehot_decoder #(.IN_W(ADDR_W)) wbDecoder (
        .in     (bus.wb_rd),
        .enable (bus.wb_valid),
        .out    (wbDec)
    );

    // Decoder bits beyond NUM_REGS are dropped, so out-of-range addresses decode to zero.
    assign issueOh = issueDec[NUM_REGS-1:0];
    assign wbOh    = wbDec[NUM_REGS-1:0];

    // Zero register is masked out of every update, so its counter stays at its reset value.
    assign incVec = issueOh & ~ZERO_MASK;
    assign decVec = wbOh & ~ZERO_MASK & busyVec;
    assign ufVec  = wbOh & ~ZERO_MASK & ~busyVec & ~issueOh;

    for (genvar r = 0; r < NUM_REGS; r++) begin : gCnt
        assign busyVec[r] = (cnt[r] != '0);

        // Per-register pending count; simultaneous inc and dec cancel.
        always_ff @(posedge clk) begin
            if (!reset) begin
                cnt[r] <= '0;
            end else if (incVec[r] && !decVec[r]) begin
                cnt[r] <= cnt[r] + 1'b1;
            end else if (decVec[r] && !incVec[r]) begin
                cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

    // Sticky flag for a writeback that had no matching pending write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            underflowQ <= 1'b0;
        end else if (|ufVec) begin
            underflowQ <= 1'b1;
        end
    end

    // Source-operand busy lookups from registered counters only.
    always_comb begin
        rdSel       = '0;
        bus.rd_busy = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rdSel          = bus.rd_addr[i*ADDR_W +: ADDR_W];
            bus.rd_busy[i] = inRange(rdSel) && busyVec[rdSel];
        end
    end

    assign bus.issue_ready = issueReady;
    assign bus.we_en       = wbOh & ~ZERO_MASK;
    assign bus.busy_vec    = busyVec;
    assign bus.underflow   = underflowQ;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard.
module tb_reg_scoreboard;
    import cpu_regfile_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    reg_scoreboard_if #(.ADDR_W(5), .NUM_REGS(32), .NUM_RD(2)) bus ();

    reg_scoreboard #(
        .ADDR_W   (5),
        .NUM_REGS (32),
        .ZERO_REG (31),
        .CNT_W    (2),
        .NUM_RD   (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input reg_addr_t ir, input logic wv, input reg_addr_t wr);
        bus.issue_valid = iv;
        bus.issue_rd    = ir;
        bus.wb_valid    = wv;
        bus.wb_rd       = wr;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.rd_addr = '0;
        drive(1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (bus.busy_vec !== 32'h0) begin
            failures++;
            $display("FAIL reset_busy got=%h exp=%h", bus.busy_vec, 32'h0);
        end
        checks++;
        if (bus.underflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_underflow got=%b exp=0", bus.underflow);
        end
        checks++;
        if (bus.issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", bus.issue_ready);
        end
        checks++;
        if (bus.we_en !== 32'h0) begin
            failures++;
            $display("FAIL reset_we got=%h exp=%h", bus.we_en, 32'h0);
        end
    endtask

    task automatic test_issue_wb();
        bus.rd_addr = {5'd31, 5'd5};
        drive(1'b1, 5'd5, 1'b0, 5'd0);
        checks++;
        if (bus.busy_vec !== 32'h0) begin
            failures++;
            $display("FAIL iw_nobypass got=%h exp=%h", bus.busy_vec, 32'h0);
        end
        tick();
        drive(1'b0, 5'd0, 1'b0, 5'd0);
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (bus.busy_vec !== 32'h20) begin
                failures++;
                $display("FAIL iw_busy_c%0d got=%h exp=%h", c, bus.busy_vec, 32'h20);
            end
            checks++;
            if (bus.rd_busy !== 2'b01) begin
                failures++;
                $display("FAIL iw_rdbusy_c%0d got=%b exp=01", c, bus.rd_busy);
            end
            if (c < 3) tick();
        end
        drive(1'b0, 5'd0, 1'b1, 5'd5);
        checks++;
        if (bus.we_en !== 32'h20) begin
            failures++;
            $display("FAIL iw_we got=%h exp=%h", bus.we_en, 32'h20);
        end
        tick();
        drive(1'b0, 5'd0, 1'b0, 5'd0);
        checks++;
        if (bus.busy_vec !== 32'h0) begin
            failures++;
            $display("FAIL iw_cleared got=%h exp=%h", bus.busy_vec, 32'h0);
        end
        checks++;
        if (bus.we_en !== 32'h0) begin
            failures++;
            $display("FAIL iw_we_idle got=%h exp=%h", bus.we_en, 32'h0);
        end
        bus.rd_addr = {5'd5, 5'd31};
        #1;
        checks++;
        if (bus.rd_busy !== 2'b00) begin
            failures++;
            $display("FAIL iw_rdbusy_idle got=%b exp=00", bus.rd_busy);
        end
    endtask

    task automatic test_zero_reg();
        drive(1'b1, 5'd31, 1'b0, 5'd0);
        checks++;
        if (bus.issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL zr_ready got=%b exp=1", bus.issue_ready);
        end
        tick();
        drive(1'b0, 5'd0, 1'b1, 5'd31);
        checks++;
        if (bus.busy_vec !== 32'h0) begin
            failures++;
            $display("FAIL zr_busy got=%h exp=%h", bus.busy_vec, 32'h0);
        end
        checks++;
        if (bus.we_en !== 32'h0) begin
            failures++;
            $display("FAIL zr_we got=%h exp=%h", bus.we_en, 32'h0);
        end
        tick();
        drive(1'b0, 5'd0, 1'b0, 5'd0);
        checks++;
        if (bus.underflow !== 1'b0) begin
            failures++;
            $display("FAIL zr_underflow got=%b exp=0", bus.underflow);
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'd7, 1'b0, 5'd0);
            checks++;
            if (bus.issue_ready !== 1'b1) begin
                failures++;
                $display("FAIL sat_ready_%0d got=%b exp=1", k, bus.issue_ready);
            end
            tick();
        end
        drive(1'b1, 5'd7, 1'b0, 5'd0);
        checks++;
        if (bus.issue_ready !== 1'b0) begin
            failures++;
            $display("FAIL sat_full got=%b exp=0", bus.issue_ready);
        end
        tick();
        checks++;
        if (bus.busy_vec !== 32'h80) begin
            failures++;
            $display("FAIL sat_nowrap got=%h exp=%h", bus.busy_vec, 32'h80);
        end
        drive(1'b1, 5'd7, 1'b1, 5'd7);
        checks++;
        if (bus.issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL sat_wb_ready got=%b exp=1", bus.issue_ready);
        end
        checks++;
        if (bus.we_en !== 32'h80) begin
            failures++;
            $display("FAIL sat_we got=%h exp=%h", bus.we_en, 32'h80);
        end
        tick();
        drive(1'b1, 5'd7, 1'b0, 5'd0);
        checks++;
        if (bus.issue_ready !== 1'b0) begin
            failures++;
            $display("FAIL sat_still_full got=%b exp=0", bus.issue_ready);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 5'd0, 1'b1, 5'd7);
            tick();
        end
        drive(1'b0, 5'd0, 1'b0, 5'd0);
        checks++;
        if (bus.busy_vec !== 32'h0) begin
            failures++;
            $display("FAIL sat_drained got=%h exp=%h", bus.busy_vec, 32'h0);
        end
        checks++;
        if (bus.underflow !== 1'b0) begin
            failures++;
            $display("FAIL sat_underflow got=%b exp=0", bus.underflow);
        end
    endtask

    task automatic test_simultaneous();
        drive(1'b1, 5'd9, 1'b0, 5'd0);
        tick();
        drive(1'b1, 5'd9, 1'b1, 5'd9);
        tick();
        drive(1'b0, 5'd0, 1'b0, 5'd0);
        checks++;
        if (bus.busy_vec !== 32'h200) begin
            failures++;
            $display("FAIL sim_same_busy got=%h exp=%h", bus.busy_vec, 32'h200);
        end
        drive(1'b0, 5'd0, 1'b1, 5'd9);
        tick();
        drive(1'b0, 5'd0, 1'b0, 5'd0);
        checks++;
        if (bus.busy_vec !== 32'h0) begin
            failures++;
            $display("FAIL sim_same_cnt1 got=%h exp=%h", bus.busy_vec, 32'h0);
        end
        drive(1'b1, 5'd4, 1'b0, 5'd0);
        tick();
        drive(1'b1, 5'd2, 1'b1, 5'd4);
        tick();
        drive(1'b0, 5'd0, 1'b0, 5'd0);
        checks++;
        if (bus.busy_vec !== 32'h4) begin
            failures++;
            $display("FAIL sim_indep got=%h exp=%h", bus.busy_vec, 32'h4);
        end
        drive(1'b0, 5'd0, 1'b1, 5'd2);
        tick();
        drive(1'b0, 5'd0, 1'b0, 5'd0);
        checks++;
        if ((bus.busy_vec !== 32'h0) || (bus.underflow !== 1'b0)) begin
            failures++;
            $display("FAIL sim_clean got busy=%h uf=%b exp busy=0 uf=0", bus.busy_vec, bus.underflow);
        end
    endtask

    task automatic test_underflow();
        drive(1'b0, 5'd0, 1'b1, 5'd12);
        checks++;
        if (bus.we_en !== 32'h1000) begin
            failures++;
            $display("FAIL uf_we got=%h exp=%h", bus.we_en, 32'h1000);
        end
        checks++;
        if (bus.underflow !== 1'b0) begin
            failures++;
            $display("FAIL uf_early got=%b exp=0", bus.underflow);
        end
        tick();
        drive(1'b0, 5'd0, 1'b0, 5'd0);
        checks++;
        if (bus.underflow !== 1'b1) begin
            failures++;
            $display("FAIL uf_set got=%b exp=1", bus.underflow);
        end
        tick();
        tick();
        checks++;
        if ((bus.underflow !== 1'b1) || (bus.busy_vec !== 32'h0)) begin
            failures++;
            $display("FAIL uf_held got uf=%b busy=%h exp uf=1 busy=0", bus.underflow, bus.busy_vec);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 5'd3, 1'b0, 5'd0);
        tick();
        tick();
        drive(1'b0, 5'd0, 1'b0, 5'd0);
        checks++;
        if ((bus.busy_vec !== 32'h8) || (bus.underflow !== 1'b1)) begin
            failures++;
            $display("FAIL rm_pre got busy=%h uf=%b exp busy=8 uf=1", bus.busy_vec, bus.underflow);
        end
        reset = 1'b0;
        drive(1'b1, 5'd3, 1'b1, 5'd12);
        tick();
        reset = 1'b1;
        drive(1'b1, 5'd3, 1'b0, 5'd0);
        checks++;
        if (bus.busy_vec !== 32'h0) begin
            failures++;
            $display("FAIL rm_busy got=%h exp=%h", bus.busy_vec, 32'h0);
        end
        checks++;
        if (bus.underflow !== 1'b0) begin
            failures++;
            $display("FAIL rm_underflow got=%b exp=0", bus.underflow);
        end
        checks++;
        if (bus.issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL rm_ready got=%b exp=1", bus.issue_ready);
        end
        drive(1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    initial begin
        test_reset();
        test_issue_wb();
        test_zero_reg();
        test_saturation();
        test_simultaneous();
        test_underflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
